// File: rtl/dct_transpose_pp.sv
// dct_transpose_pp
//   Ping-pong transpose buffer between the row and column 1-D DCT stages.
//   Blocks of N x N words arrive one row per beat and leave one column per
//   beat. Two banks let block k+1 fill while block k drains.
//
//   Parameters : N (block dimension, 2..16), W (word width, default 33)
//   Ports      : clk, reset (async, active low)
//                in_data/in_valid/in_ready      row input, valid/ready
//                out_data/out_valid/out_ready   column output, valid/ready
//                out_first/out_last             column 0 / column N-1 markers
//                mode                           only with TPB_PASSTHRU_EN:
//                                               1 = emit rows untransposed
//
//   Optional feature macro: TPB_PASSTHRU_EN

// One storage lane holds row ROW of both banks. It exposes the word selected
// by the read column index, and (passthru builds) the whole row.
module dct_tpb_lane #(
  parameter int N  = 4,
  parameter int W  = 33,
  parameter int RW = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic                  wr_bank,
  input  logic [N-1:0][W-1:0]   wr_data,
  input  logic                  rd_bank,
  input  logic [RW-1:0]         rd_idx,
  output logic [W-1:0]          col_word
`ifdef TPB_PASSTHRU_EN
  ,
  output logic [N-1:0][W-1:0]   row_words
`endif
);
  logic [1:0][N-1:0][W-1:0] mem;

  always_ff @(posedge clk or negedge reset)
    if (!reset)  mem <= '0;
    else if (we) mem[wr_bank] <= wr_data;

  assign col_word = mem[rd_bank][rd_idx];
`ifdef TPB_PASSTHRU_EN
  assign row_words = mem[rd_bank];
`endif
endmodule

module dct_transpose_pp #(
  parameter int N = 4,
  parameter int W = 33
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N*W-1:0] in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [N*W-1:0] out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_first,
  output logic           out_last
`ifdef TPB_PASSTHRU_EN
  ,
  input  logic           mode
`endif
);
  localparam int RW = $clog2(N);
  localparam logic [RW-1:0] LAST = RW'(N - 1);

  logic [1:0]    full;
  logic          wr_bank, rd_bank;
  logic [RW-1:0] wr_row, rd_idx;
  logic          wr_fire, rd_fire;

  logic [N-1:0][W-1:0] in_row;
  logic [N-1:0][W-1:0] col_words;   // col_words[r] = mem[rd_bank][r][rd_idx]

  assign in_row    = in_data;
  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;
  assign out_first = out_valid && (rd_idx == '0);
  assign out_last  = out_valid && (rd_idx == LAST);

  // Write and read sides complete blocks in different banks, so the set and
  // clear below never hit the same full bit in one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_row  <= '0;
      rd_idx  <= '0;
    end else begin
      if (wr_fire) begin
        if (wr_row == LAST) begin
          full[wr_bank] <= 1'b1;
          wr_row        <= '0;
          wr_bank       <= !wr_bank;
        end else begin
          wr_row <= wr_row + 1'b1;
        end
      end
      if (rd_fire) begin
        if (rd_idx == LAST) begin
          full[rd_bank] <= 1'b0;
          rd_idx        <= '0;
          rd_bank       <= !rd_bank;
        end else begin
          rd_idx <= rd_idx + 1'b1;
        end
      end
    end
  end

`ifdef TPB_PASSTHRU_EN
  logic [N-1:0][N-1:0][W-1:0] row_words;
  logic                       mode_q;
  logic                       row_mode;

  // Mode is taken live on column 0 and held for the remaining columns.
  always_ff @(posedge clk or negedge reset)
    if (!reset)                          mode_q <= 1'b0;
    else if (rd_fire && rd_idx == '0)    mode_q <= mode;

  assign row_mode = (rd_idx == '0) ? mode : mode_q;
`endif

  for (genvar r = 0; r < N; r++) begin : g_lane
    dct_tpb_lane #(.N(N), .W(W), .RW(RW)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .we       (wr_fire && (wr_row == RW'(r))),
      .wr_bank  (wr_bank),
      .wr_data  (in_row),
      .rd_bank  (rd_bank),
      .rd_idx   (rd_idx),
      .col_word (col_words[r])
`ifdef TPB_PASSTHRU_EN
      ,
      .row_words(row_words[r])
`endif
    );
  end

`ifdef TPB_PASSTHRU_EN
  assign out_data = row_mode ? row_words[rd_idx] : col_words;
`else
  assign out_data = col_words;
`endif
endmodule

// File: doc/dct_transpose_pp.md
# dct_transpose_pp

Parametrised ping-pong transpose buffer between the row and column 1-D DCT stages of the 2-D DCT datapath. It accepts N×N blocks one row per beat: a row is N packed 33-bit float words {sign, exp[7:0], mant[23:0]}. It returns each block one column per beat, so the second 1-D DCT sees transposed data. Two banks allow a full-rate write of block k+1 while block k drains. Valid/ready handshakes on both sides replace the free-running counter and fixed shift-register delays.

## Interface
- N, default 4: block dimension (rows = columns = words per beat); legal values 2..16.
- W, default 33: word width in bits (1 sign + 8 exponent + 24 mantissa).
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous active-low reset (0 = reset asserted).
- in_data  input  N*W  one row; element c at in_data[c*W +: W].
- in_valid  input  1  in_data holds a valid row.
- in_ready  output  1  buffer can accept a row this cycle.
- out_data  output  N*W  one column; element r at out_data[r*W +: W].
- out_valid  output  1  out_data holds a valid column.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_first  output  1  current output beat is column 0 of a block.
- out_last  output  1  current output beat is column N-1 of a block.
- mode  input  1  present only with TPB_PASSTHRU_EN; see Configuration.

## Operation
- Storage: two banks, each N×N words (mem[bank][row][col]). Write-side state: wr_bank (1 bit) and wr_row (clog2 N bits). Read-side state: rd_bank and rd_idx. Per-bank full flag: full[1:0].
- Write fire = in_valid & in_ready, where in_ready = !full[wr_bank]. On a write fire, mem[wr_bank][wr_row][c] <= in_data[c] for all c. wr_row then increments.
- On a write fire with wr_row == N-1: full[wr_bank] <= 1, wr_row <= 0, and wr_bank toggles.
- Read fire = out_valid & out_ready, where out_valid = full[rd_bank]. out_data[r] = mem[rd_bank][r][rd_idx]. This is a combinational select from registered storage; no data register on the output.
- On a read fire, rd_idx increments. On a read fire with rd_idx == N-1: full[rd_bank] <= 0, rd_idx <= 0, and rd_bank toggles.
- out_first = out_valid & (rd_idx == 0). out_last = out_valid & (rd_idx == N-1).
- Simultaneous events:
  - A block-completing write and a block-completing read in the same cycle always target different banks. Both take effect.
  - A set and a clear of the same bank's full flag in one cycle are impossible by construction.
- Both banks full: in_ready = 0 and in_valid is ignored. Both banks empty: out_valid = 0 and out_data still shows mem[rd_bank][*][rd_idx].
- in_data is only sampled on a fire. Holding in_valid high with in_ready low has no effect.
- Downstream must keep out_ready meaningful only while out_valid is high. The block places no requirement on out_ready otherwise.

## Timing
- Reset values (asynchronous, immediate):
  - State: full = 00, wr_bank = rd_bank = 0, wr_row = rd_idx = 0, all mem words = 0.
  - Outputs: in_ready = 1, out_valid = 0, out_first = 0, out_last = 0, out_data = 0.
- Latency: the first column of a block is valid in the cycle after the write fire of its last row.
- Throughput: one row in and one column out per cycle, sustained, with in_valid and out_ready held high.
- Reset asserted mid-block: any partial block and any undrained block are discarded. Operation resumes from bank 0, row 0 after reset releases.
- Reset release: deassertion is synchronised externally. The first write fire can occur on the first rising edge with reset high.

## Configuration
- TPB_PASSTHRU_EN defined:
  - Adds the mode input, sampled on the read fire of column 0 and latched for the rest of that block.
  - mode = 0: transpose as above.
  - mode = 1: row order, out_data[c] = mem[rd_bank][rd_idx][c]. Used to bypass the transpose for 1-D-only runs.
  - Changing mode mid-block has no effect until the next block.
- TPB_PASSTHRU_EN undefined: the mode port is absent and the block always transposes.

## Test plan
- Reset check: hold reset = 0 -> in_ready = 1, out_valid = 0, out_data = 0. Release, write 4 rows with word(r,c) = 16r+c, N = 4 -> the cycle after the 4th write, out_valid = 1 and out_first = 1. Columns read 0,16,32,48 / 1,17,33,49 / 2,18,34,50 / 3,19,35,51. out_last = 1 on the 4th column.
- Back-pressure: out_ready = 0, stream 8 rows -> in_ready drops after the 8th write and the 9th row is not accepted. Raise out_ready -> 8 columns drain in order, and in_ready returns the cycle after the 4th read.
- Continuous stream: in_valid = out_ready = 1 for 40 cycles -> no bubble after initial fill, and 9 complete blocks match the golden transpose.
- Random valid/ready (50% each, 1000 blocks, random 33-bit words) -> scoreboard match with no loss or duplication.
- Mid-block reset: assert reset after 2 rows of block 1 while block 0 is draining -> all flags clear, and a new block written afterwards emerges correctly from bank 0.
- With TPB_PASSTHRU_EN and mode = 1 at column 0 -> rows emerge untransposed (0,1,2,3 first). A mode toggle during the block takes effect only on the next block.
